// File: rtl/pwr_pkg.sv
// pwr_pkg: power sequencer state codes, simulation timing defaults and helpers.
package pwr_pkg;

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_ON_ARM  = 3'd1,
        S_ON      = 3'd2,
        S_HOLD    = 3'd3,
        S_OFF_REL = 3'd4
    } pwr_state_e;

    localparam int unsigned SIM_LONG_CYCLES = 8;
    localparam int unsigned SIM_GESTURE_WIN = 10;
    localparam int unsigned SIM_IDLE_CYCLES = 20;

    function automatic logic is_powered(input pwr_state_e s);
        return s inside {S_ON_ARM, S_ON, S_HOLD};
    endfunction

endpackage

// File: rtl/gesture_detect.sv
// gesture_detect: two-pulse swipe tracker; seq_lr/seq_rl pulse when the opposite
// sensor fires inside the window after the first one.
module gesture_detect
    import pwr_pkg::*;
#(
    parameter int unsigned WIN   = SIM_GESTURE_WIN,
    parameter int unsigned CNT_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic left,
    input  logic right,
    output logic seq_lr,
    output logic seq_rl
);

    logic             arm_l_q, arm_l_d, arm_r_q, arm_r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_win;

    // Completion outputs depend only on registered state so clr may follow the FSM.
    assign in_win = cnt_q < CNT_W'(WIN);
    assign seq_lr = en && right && !left && arm_l_q && in_win;
    assign seq_rl = en && left && !right && arm_r_q && in_win;

    always_comb begin
        arm_l_d = arm_l_q;
        arm_r_d = arm_r_q;
        cnt_d   = cnt_q;
        if (!en || clr || (left && right) || seq_lr || seq_rl) begin
            arm_l_d = 1'b0;
            arm_r_d = 1'b0;
            cnt_d   = '0;
        end else if (left || right) begin
            arm_l_d = left;
            arm_r_d = right;
            cnt_d   = '0;
        end else if (arm_l_q || arm_r_q) begin
            arm_l_d = in_win && arm_l_q;
            arm_r_d = in_win && arm_r_q;
            cnt_d   = in_win ? cnt_q + CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_l_q <= 1'b0;
            arm_r_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            arm_l_q <= arm_l_d;
            arm_r_q <= arm_r_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/power_ctrl.sv
// power_ctrl: power-state sequencer combining button, swipe gestures and idle
// timeout into a registered power_on level with on/off event pulses.
module power_ctrl
    import pwr_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = 300_000_000,
    parameter int unsigned GESTURE_WIN = 500_000_000,
    parameter int unsigned IDLE_CYCLES = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_power,
    input  logic       gesture_left,
    input  logic       gesture_right,
    input  logic       activity,
    output logic       power_on,
    output logic       on_pulse,
    output logic       off_pulse,
    output logic [2:0] pwr_state
);

    pwr_state_e       state_q, state_d;
    logic             btn_q, btn_d, btn_ok_q, btn_ok_d;
    logic             power_on_q, power_on_d, on_pulse_q, on_pulse_d, off_pulse_q, off_pulse_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d, idle_cnt_q, idle_cnt_d, hold_next;
    logic             btn_rise, idle_hit, seq_lr, seq_rl, gest_en, gest_clr;

    assign gest_en  = (state_q == S_OFF) || (state_q == S_ON);
    assign gest_clr = state_d != state_q;

    gesture_detect #(.WIN(GESTURE_WIN), .CNT_W(CNT_W)) u_gesture (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (gest_clr),
        .en     (gest_en),
        .left   (gesture_left),
        .right  (gesture_right),
        .seq_lr (seq_lr),
        .seq_rl (seq_rl)
    );

    always_comb begin
        btn_d      = btn_power;
        // A button already held at reset release must be let go before it counts.
        btn_ok_d   = btn_ok_q || !btn_power;
        btn_rise   = btn_power && !btn_q && btn_ok_q;
        hold_next  = hold_cnt_q + CNT_W'(1);
        idle_cnt_d = '0;
        if (state_q == S_ON && !(activity || btn_power || gesture_left || gesture_right))
            idle_cnt_d = (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + CNT_W'(1);
        idle_hit   = (IDLE_CYCLES != 0) && (idle_cnt_d >= CNT_W'(IDLE_CYCLES));
        state_d    = state_q;
        hold_cnt_d = '0;
        case (state_q)
            S_OFF:     state_d = btn_rise ? S_ON_ARM : seq_lr ? S_ON : S_OFF;
            S_ON_ARM:  state_d = btn_power ? S_ON_ARM : S_ON;
            S_ON: begin
                state_d    = btn_rise ? S_HOLD : (seq_rl || idle_hit) ? S_OFF : S_ON;
                hold_cnt_d = btn_rise ? CNT_W'(1) : '0;
            end
            S_HOLD: begin
                state_d    = !btn_power ? S_ON : (hold_next >= CNT_W'(LONG_CYCLES)) ? S_OFF_REL : S_HOLD;
                hold_cnt_d = btn_power ? hold_next : '0;
            end
            S_OFF_REL: state_d = btn_power ? S_OFF_REL : S_OFF;
            default:   state_d = S_OFF;
        endcase
        power_on_d  = is_powered(state_d);
        on_pulse_d  = power_on_d && !power_on_q;
        off_pulse_d = !power_on_d && power_on_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            btn_q       <= 1'b0;
            btn_ok_q    <= 1'b0;
            power_on_q  <= 1'b0;
            on_pulse_q  <= 1'b0;
            off_pulse_q <= 1'b0;
            hold_cnt_q  <= '0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            btn_q       <= btn_d;
            btn_ok_q    <= btn_ok_d;
            power_on_q  <= power_on_d;
            on_pulse_q  <= on_pulse_d;
            off_pulse_q <= off_pulse_d;
            hold_cnt_q  <= hold_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign power_on  = power_on_q;
    assign on_pulse  = on_pulse_q;
    assign off_pulse = off_pulse_q;
    assign pwr_state = state_q;

endmodule

// File: tb/tb_power_ctrl.sv
// tb_power_ctrl: directed vectors with hand-computed expectations for power_ctrl
// at LONG=8, WIN=10, IDLE=20.
module tb_power_ctrl;
    import pwr_pkg::*;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       btn_power = 1'b0, gesture_left = 1'b0, gesture_right = 1'b0, activity = 1'b0;
    logic       power_on, on_pulse, off_pulse;
    logic [2:0] pwr_state;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    power_ctrl #(
        .LONG_CYCLES (8),
        .GESTURE_WIN (10),
        .IDLE_CYCLES (20),
        .CNT_W       (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_power     (btn_power),
        .gesture_left  (gesture_left),
        .gesture_right (gesture_right),
        .activity      (activity),
        .power_on      (power_on),
        .on_pulse      (on_pulse),
        .off_pulse     (off_pulse),
        .pwr_state     (pwr_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int st, input bit pon, input bit onp, input bit offp);
        check({tag, ".state"}, 32'(pwr_state), 32'(st));
        check({tag, ".power_on"}, 32'(power_on), 32'(pon));
        check({tag, ".on_pulse"}, 32'(on_pulse), 32'(onp));
        check({tag, ".off_pulse"}, 32'(off_pulse), 32'(offp));
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_left;
        gesture_left = 1'b1; step(1); gesture_left = 1'b0;
    endtask

    task automatic pulse_right;
        gesture_right = 1'b1; step(1); gesture_right = 1'b0;
    endtask

    task automatic btn_on;
        btn_power = 1'b1; step(1); btn_power = 1'b0; step(1);
    endtask

    initial begin
        step(2);
        expect_out("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        step(3);
        expect_out("idle_after_reset", 0, 0, 0, 0);

        btn_power = 1'b1; step(1);
        expect_out("press_on", 1, 1, 1, 0);
        step(1);
        expect_out("press_held", 1, 1, 0, 0);
        step(1);
        btn_power = 1'b0; step(1);
        expect_out("release_on", 2, 1, 0, 0);

        btn_power = 1'b1; step(7);
        expect_out("long_hold7", 3, 1, 0, 0);
        step(1);
        expect_out("long_hold8", 4, 0, 0, 1);
        step(1);
        expect_out("long_still", 4, 0, 0, 0);
        btn_power = 1'b0; step(1);
        expect_out("long_release", 0, 0, 0, 0);

        btn_on();
        expect_out("on_again", 2, 1, 0, 0);
        btn_power = 1'b1; step(5);
        expect_out("short_hold", 3, 1, 0, 0);
        btn_power = 1'b0; step(1);
        expect_out("short_release", 2, 1, 0, 0);

        pulse_right(); step(2); pulse_left();
        expect_out("rl_off", 0, 0, 0, 1);

        pulse_left(); step(5); pulse_right();
        expect_out("lr_gap6", 2, 1, 1, 0);
        pulse_right(); step(2); pulse_left();
        expect_out("rl_off2", 0, 0, 0, 1);

        pulse_left(); step(11); pulse_right();
        expect_out("lr_gap12", 0, 0, 0, 0);
        pulse_left();
        expect_out("rl_in_off", 0, 0, 0, 0);
        pulse_left(); step(10); pulse_right();
        expect_out("lr_gap11", 0, 0, 0, 0);
        step(12);
        pulse_left(); step(9); pulse_right();
        expect_out("lr_gap10", 2, 1, 1, 0);

        gesture_left = 1'b1; gesture_right = 1'b1; step(1);
        gesture_left = 1'b0; gesture_right = 1'b0;
        expect_out("both_same", 2, 1, 0, 0);
        pulse_right();
        gesture_left = 1'b1; gesture_right = 1'b1; step(1);
        gesture_left = 1'b0; gesture_right = 1'b0;
        pulse_left();
        expect_out("both_disarm", 2, 1, 0, 0);

        pulse_right(); step(8); pulse_right(); step(8); pulse_left();
        expect_out("rearm_off", 0, 0, 0, 1);

        btn_on(); step(19);
        expect_out("idle19", 2, 1, 0, 0);
        step(1);
        expect_out("idle20", 0, 0, 0, 1);

        btn_on(); step(14);
        activity = 1'b1; step(1); activity = 1'b0;
        step(19);
        expect_out("act_idle34", 2, 1, 0, 0);
        step(1);
        expect_out("act_idle35", 0, 0, 0, 1);

        btn_on();
        btn_power = 1'b1; step(3);
        expect_out("hold_pre_rst", 3, 1, 0, 0);
        rst_n = 1'b0; #2;
        expect_out("async_rst", 0, 0, 0, 0);
        step(2);
        rst_n = 1'b1; step(5);
        expect_out("held_through_rst", 0, 0, 0, 0);
        btn_power = 1'b0; step(1);
        btn_power = 1'b1; step(1);
        expect_out("new_edge", 1, 1, 1, 0);
        btn_power = 1'b0; step(1);
        expect_out("new_edge_rel", 2, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
